rv_mdu_exec: RTL and testbench



---
 rtl/rv_mdu_pkg.sv | 39 +++
 rtl/rv_mdu_divider.sv | 83 ++++++++
 rtl/rv_mdu_exec.sv | 222 ++++++++++++++++++++++
 tb/tb_rv_mdu_exec.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mdu_pkg.sv
// Shared types and width helpers for the M-extension execute unit.
// Holds funct3 op codes, FSM states, product and counter widths.
package rv_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_t;

    // Operand width after sign/zero extension.
    function automatic int ext_w(int xlen);
        return xlen + 1;
    endfunction

    // Kept product width; bits above 2*XLEN of the
    // (2*XLEN+2)-bit extended product are never selected.
    function automatic int prod_w(int xlen);
        return 2 * xlen;
    endfunction

    // Iteration counter width: 6 bits for 32, 7 for 64.
    function automatic int cnt_w(int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/rv_mdu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports: i_start/i_clear control, i_iters preload, o_busy/o_done, quotient, remainder.
module rv_mdu_divider
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = cnt_w(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic [CW-1:0]   i_iters,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;

    logic [XLEN-1:0] src_rem, src_quo, src_dvs;
    logic [XLEN-1:0] nxt_rem, nxt_quo;
    logic [XLEN:0]   shifted, diff;

    // The start edge performs the first iteration directly
    // from the preload. Skipped leading zeros are shifted
    // out of the dividend up front.
    always_comb begin
        src_rem = i_start ? '0 : rem_q;
        src_quo = i_start ?
            (i_dividend << (CW'(XLEN) - i_iters)) : quo_q;
        src_dvs = i_start ? i_divisor : dvs_q;
        shifted = {src_rem, src_quo[XLEN-1]};
        diff    = shifted - {1'b0, src_dvs};
        if (!diff[XLEN]) begin
            nxt_rem = diff[XLEN-1:0];
            nxt_quo = {src_quo[XLEN-2:0], 1'b1};
        end else begin
            nxt_rem = shifted[XLEN-1:0];
            nxt_quo = {src_quo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (i_clear) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (i_start) begin
            rem_q  <= nxt_rem;
            quo_q  <= nxt_quo;
            dvs_q  <= i_divisor;
            cnt_q  <= i_iters - CW'(1);
            busy_q <= (i_iters != CW'(1));
            done_q <= (i_iters == CW'(1));
        end else if (busy_q) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;

endmodule

// File: rtl/rv_mdu_exec.sv
// Multi-cycle RISC-V M-extension execute unit (MUL*/DIV*/REM*).
// Ports: decode request (i_valid/i_op/i_rs1/i_rs2/i_rd_addr), i_stall/i_flush,
// o_ready/o_stall back to decode, o_valid/o_result/o_rd_addr to writeback.
// Build option: DIV_EARLY_OUT_EN skips leading zeros of |rs1| in the divider.
module rv_mdu_exec
    import rv_mdu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int RD_ADDR_W   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [2:0]           i_op,
    input  logic [XLEN-1:0]      i_rs1,
    input  logic [XLEN-1:0]      i_rs2,
    input  logic [RD_ADDR_W-1:0] i_rd_addr,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic                 o_ready,
    output logic                 o_stall,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_result,
    output logic [RD_ADDR_W-1:0] o_rd_addr
);

    localparam int EW = ext_w(XLEN);
    localparam int PW = prod_w(XLEN);
    localparam int CW = cnt_w(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t           state;
    mdu_op_t              op_q;
    mdu_op_t              op_in;
    logic [XLEN-1:0]      a_q, b_q;
    logic [RD_ADDR_W-1:0] rd_q;
    logic [1:0]           mul_cnt;
    logic                 div_setup;
    logic                 accept;

    assign op_in   = mdu_op_t'(i_op);
    assign o_ready = (state == S_IDLE) ||
                     (state == S_DONE && !i_stall);
    assign accept  = i_valid && o_ready && !i_flush;
    assign o_stall = (state == S_MUL) || (state == S_DIV) || accept;

    // Multiplier: operands extended by one bit so every
    // variant is a single signed multiply.
    logic                 a_sgn, b_sgn;
    logic signed [EW-1:0] a_x, b_x;
    logic [PW-1:0]        prod_in, prod_tap;

    assign a_sgn   = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign b_sgn   = (op_in == OP_MULH);
    assign a_x     = {a_sgn & i_rs1[XLEN-1], i_rs1};
    assign b_x     = {b_sgn & i_rs2[XLEN-1], i_rs2};
    assign prod_in = PW'(a_x) * PW'(b_x);

    // Product register chain; the final stage is o_result.
    if (MUL_LATENCY > 1) begin : g_pipe
        logic [PW-1:0] pipe [MUL_LATENCY-1];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int k = 0; k < MUL_LATENCY-1; k++)
                    pipe[k] <= '0;
            end else begin
                pipe[0] <= prod_in;
                for (int k = 1; k < MUL_LATENCY-1; k++)
                    pipe[k] <= pipe[k-1];
            end
        end
        assign prod_tap = pipe[MUL_LATENCY-2];
    end else begin : g_nopipe
        assign prod_tap = prod_in;
    end

    function automatic logic [XLEN-1:0] sel_prod(
        mdu_op_t op, logic [PW-1:0] p);
        return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    // Divider sign handling. Signed ops have funct3[0]==0.
    logic            div_sgn, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, div_start;
    logic [XLEN-1:0] spec_res, fix_res;
    logic [XLEN-1:0] div_q, div_r;
    logic            div_busy, div_done;
    logic [CW-1:0]   div_iters;

    assign div_sgn  = !op_q[0];
    assign a_neg    = div_sgn & a_q[XLEN-1];
    assign b_neg    = div_sgn & b_q[XLEN-1];
    assign mag_a    = a_neg ? -a_q : a_q;
    assign mag_b    = b_neg ? -b_q : b_q;
    assign div_zero = (b_q == '0);
    assign div_ovf  = div_sgn && (a_q == XMIN) && (b_q == '1);

    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = op_q[1] ? a_q : '1;
        else if (div_ovf)
            spec_res = op_q[1] ? '0 : a_q;
    end

    // Quotient sign follows rs1^rs2, remainder follows rs1.
    assign fix_res = op_q[1] ? (a_neg ? -div_r : div_r)
                             : ((a_neg ^ b_neg) ? -div_q : div_q);

`ifdef DIV_EARLY_OUT_EN
    function automatic logic [CW-1:0] clz(logic [XLEN-1:0] v);
        clz = CW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (v[i]) clz = CW'(XLEN - 1 - i);
    endfunction

    logic [CW-1:0] lz;
    assign lz        = clz(mag_a);
    // A zero dividend still runs one iteration.
    assign div_iters = (lz == CW'(XLEN)) ? CW'(1)
                                         : CW'(XLEN) - lz;
`else
    assign div_iters = CW'(XLEN);
`endif

    assign div_start = (state == S_DIV) && div_setup &&
                       !div_zero && !div_ovf && !i_flush;

    rv_mdu_divider #(
        .XLEN (XLEN),
        .CW   (CW)
    ) u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_flush),
        .i_start     (div_start),
        .i_dividend  (mag_a),
        .i_divisor   (mag_b),
        .i_iters     (div_iters),
        .o_busy      (div_busy),
        .o_done      (div_done),
        .o_quotient  (div_q),
        .o_remainder (div_r)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            mul_cnt   <= '0;
            div_setup <= 1'b0;
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_rd_addr <= '0;
        end else if (i_flush) begin
            state     <= S_IDLE;
            mul_cnt   <= '0;
            div_setup <= 1'b0;
            o_valid   <= 1'b0;
        end else if (accept) begin
            op_q      <= op_in;
            a_q       <= i_rs1;
            b_q       <= i_rs2;
            rd_q      <= i_rd_addr;
            mul_cnt   <= 2'd1;
            div_setup <= 1'b1;
            o_valid   <= 1'b0;
            if (i_op[2]) begin
                state <= S_DIV;
            end else if (MUL_LATENCY == 1) begin
                state     <= S_DONE;
                o_valid   <= 1'b1;
                o_result  <= sel_prod(op_in, prod_in);
                o_rd_addr <= i_rd_addr;
            end else begin
                state <= S_MUL;
            end
        end else begin
            unique case (state)
                S_IDLE: ;
                S_MUL: begin
                    if (mul_cnt == 2'(MUL_LATENCY - 1)) begin
                        state     <= S_DONE;
                        o_valid   <= 1'b1;
                        o_result  <= sel_prod(op_q, prod_tap);
                        o_rd_addr <= rd_q;
                    end else begin
                        mul_cnt <= mul_cnt + 2'd1;
                    end
                end
                S_DIV: begin
                    if (div_setup) begin
                        div_setup <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state     <= S_DONE;
                            o_valid   <= 1'b1;
                            o_result  <= spec_res;
                            o_rd_addr <= rd_q;
                        end
                    end else if (div_done && !div_busy) begin
                        state     <= S_DONE;
                        o_valid   <= 1'b1;
                        o_result  <= fix_res;
                        o_rd_addr <= rd_q;
                    end
                end
                S_DONE: begin
                    if (!i_stall) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mdu_exec.sv
// Self-checking bench for rv_mdu_exec (XLEN=32): directed table,
// multi-cycle corner sequences and a random run against a reference model.
module tb_rv_mdu_exec;
    import rv_mdu_pkg::*;

    localparam int MUL_LAT = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd_addr;
    logic        i_stall, i_flush;
    logic        o_ready, o_stall, o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    rv_mdu_exec #(
        .XLEN        (32),
        .MUL_LATENCY (MUL_LAT),
        .RD_ADDR_W   (5)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_op      (i_op),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_rd_addr (i_rd_addr),
        .i_stall   (i_stall),
        .i_flush   (i_flush),
        .o_ready   (o_ready),
        .o_stall   (o_stall),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_rd_addr (o_rd_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Reference result from the M-extension arithmetic rules.
    function automatic logic [31:0] ref_mdu(
        logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divide latency from the number of significant bits of |rs1|.
    function automatic int dl(int bits);
`ifdef DIV_EARLY_OUT_EN
        return 2 + ((bits < 1) ? 1 : bits);
`else
        return 34;
`endif
    endfunction

    function automatic int exp_lat(
        logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] mag;
        int bits;
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 2;
        mag  = (!op[0] && a[31]) ? -a : a;
        bits = 0;
        while (bits < 32 && (({32'b0, mag} >> bits) != 0))
            bits++;
        return dl(bits);
    endfunction

    // Issue one op from IDLE at posedge+1, wait for the
    // result and check value, rd, latency and stall.
    task automatic run_op(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] rd,
                          input logic [31:0] exp_res,
                          input int exp_l,
                          input string tag);
        int lat;
        int stall_bad;
        i_valid = 1'b1; i_op = op; i_rs1 = a;
        i_rs2 = b; i_rd_addr = rd;
        #1;
        check({tag, " ready"}, 64'(o_ready), 64'(1));
        check({tag, " acc_stall"}, 64'(o_stall), 64'(1));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_rs1 = $urandom; i_rs2 = $urandom;
        i_rd_addr = 5'($urandom);
        lat = 1; stall_bad = 0;
        while (!o_valid && lat < 100) begin
            if (!o_stall) stall_bad++;
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_l));
        check({tag, " result"}, 64'(o_result), 64'(exp_res));
        check({tag, " rd"}, 64'(o_rd_addr), 64'(rd));
        check({tag, " busy_stall"}, 64'(stall_bad), 64'(0));
        @(posedge i_clk); #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int vcnt;
        int wd;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
        tbl[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        tbl[3]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, dl(3)};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, dl(3)};
        tbl[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, dl(7)};
        tbl[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, dl(7)};
        tbl[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2};
        tbl[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 2};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2};
        tbl[12] = '{3'd5, 32'd3, 32'd1, 32'd3, dl(2)};
        tbl[13] = '{3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2};
        tbl[14] = '{3'd5, 32'd0, 32'd5, 32'd0, dl(0)};

        i_rst_n = 1'b0; i_valid = 1'b0; i_op = '0;
        i_rs1 = '0; i_rs2 = '0; i_rd_addr = '0;
        i_stall = 1'b0; i_flush = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        check("rst valid", 64'(o_valid), 64'(0));
        check("rst result", 64'(o_result), 64'(0));
        check("rst rd", 64'(o_rd_addr), 64'(0));
        check("rst ready", 64'(o_ready), 64'(1));
        check("rst stall", 64'(o_stall), 64'(0));

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1),
                   tbl[i].res, tbl[i].lat,
                   $sformatf("vec%0d", i));

        // Hold a presented result under stall, then accept
        // a new MUL in the cycle the stall drops.
        i_stall = 1'b1;
        i_valid = 1'b1; i_op = 3'd0;
        i_rs1 = 32'd6; i_rs2 = 32'd7; i_rd_addr = 5'd9;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wd = 0;
        while (!o_valid && wd < 20) begin
            @(posedge i_clk); #1; wd++;
        end
        check("hold wait", 64'(wd < 20), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check("hold valid", 64'(o_valid), 64'(1));
            check("hold result", 64'(o_result), 64'd42);
            check("hold rd", 64'(o_rd_addr), 64'(9));
            check("hold ready", 64'(o_ready), 64'(0));
            @(posedge i_clk); #1;
        end
        i_stall = 1'b0;
        i_valid = 1'b1; i_op = 3'd0;
        i_rs1 = 32'd3; i_rs2 = 32'd5; i_rd_addr = 5'd4;
        #1;
        check("b2b ready", 64'(o_ready), 64'(1));
        check("b2b old valid", 64'(o_valid), 64'(1));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int k = 1; k < MUL_LAT; k++) begin
            check("b2b early", 64'(o_valid), 64'(0));
            @(posedge i_clk); #1;
        end
        check("b2b valid", 64'(o_valid), 64'(1));
        check("b2b result", 64'(o_result), 64'd15);
        check("b2b rd", 64'(o_rd_addr), 64'(4));
        @(posedge i_clk); #1;

        // Flush around iteration 10 of a long divide.
        i_valid = 1'b1; i_op = 3'd5;
        i_rs1 = 32'h1234_5678; i_rs2 = 32'd3; i_rd_addr = 5'd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        check("flush pre stall", 64'(o_stall), 64'(1));
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush stall", 64'(o_stall), 64'(0));
        check("flush ready", 64'(o_ready), 64'(1));
        vcnt = 0;
        repeat (40) begin
            if (o_valid) vcnt++;
            @(posedge i_clk); #1;
        end
        check("flush no valid", 64'(vcnt), 64'(0));

        // Flush together with a request: not accepted.
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0;
        i_rs1 = 32'd2; i_rs2 = 32'd2;
        #1;
        check("flush+valid stall", 64'(o_stall), 64'(0));
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        vcnt = 0;
        repeat (6) begin
            if (o_valid || o_stall) vcnt++;
            @(posedge i_clk); #1;
        end
        check("flush+valid idle", 64'(vcnt), 64'(0));

        // Flush while a result is presented drops it.
        i_stall = 1'b1;
        i_valid = 1'b1; i_op = 3'd0;
        i_rs1 = 32'd2; i_rs2 = 32'd9; i_rd_addr = 5'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wd = 0;
        while (!o_valid && wd < 20) begin
            @(posedge i_clk); #1; wd++;
        end
        check("done flush pre", 64'(o_result), 64'd18);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_stall = 1'b0;
        check("done flush valid", 64'(o_valid), 64'(0));
        check("done flush ready", 64'(o_ready), 64'(1));

        // Asynchronous reset in the middle of a divide.
        i_valid = 1'b1; i_op = 3'd4;
        i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd_addr = 5'd2;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        check("arst stall", 64'(o_stall), 64'(0));
        check("arst result", 64'(o_result), 64'(0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        vcnt = 0;
        repeat (40) begin
            if (o_valid) vcnt++;
            @(posedge i_clk); #1;
        end
        check("arst no valid", 64'(vcnt), 64'(0));

        // Random ops against the reference model.
        for (int n = 0; n < 250; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = 32'h0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin
                    ra = 32'($urandom_range(0, 255));
                    rb = 32'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            run_op(rop, ra, rb, 5'($urandom), ref_mdu(rop, ra, rb),
                   exp_lat(rop, ra, rb),
                   $sformatf("rnd%0d op%0d", n, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
